// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_st;
   typedef enum logic {GNT_IF, GNT_D} arb_gnt;

   localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signals of the memory port arbiter
interface mem_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wr, mem_wdata
   );
endinterface

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - loadable down-counter with zero flag for read latency
module mem_lat_counter
   import mem_arb_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] count,
   output logic             zero
);
   logic [LAT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = load_val;
      else if (dec && count_q != '0)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;
   assign zero  = (count_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory between fetch and load/store
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = 2
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus,
   output logic                busy,
   output logic [1:0]          State
);
   arb_st             state_q, state_d;
   arb_gnt            last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [LAT_W-1:0]  lat_count;
   logic              lat_zero;
   logic              d_wins;

`ifdef ARB_ROUND_ROBIN_EN
   assign d_wins = bus.d_req && (!bus.if_req || last_grant_q == GNT_IF);
`else
   assign d_wins = bus.d_req;
`endif

   // Loaded in ACCESS so WAIT spans exactly READ_LAT cycles before capture.
   mem_lat_counter u_lat (
      .clock    (clock),
      .reset    (reset),
      .load     (state_q == ACCESS && !we_q),
      .dec      (state_q == WAIT),
      .load_val (LAT_W'(READ_LAT - 1)),
      .count    (lat_count),
      .zero     (lat_zero)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      rdata_d      = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.if_req || bus.d_req) begin
               state_d = ACCESS;
               if (d_wins) begin
                  last_grant_d = GNT_D;
                  addr_d       = bus.d_addr;
                  wdata_d      = bus.d_wdata;
                  we_d         = bus.d_we;
               end else begin
                  last_grant_d = GNT_IF;
                  addr_d       = bus.if_addr;
                  we_d         = 1'b0;
               end
            end
         end
         ACCESS: state_d = we_q ? RESP : WAIT;
         WAIT: begin
            if (lat_zero) begin
               rdata_d = bus.mem_rdata;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_D;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wr    = (state_q == ACCESS) && we_q;
   assign bus.if_ack    = (state_q == RESP) && (last_grant_q == GNT_IF);
   assign bus.d_ack     = (state_q == RESP) && (last_grant_q == GNT_D);
   assign bus.if_rdata  = rdata_q;
   assign bus.d_rdata   = rdata_q;
   assign busy          = (state_q != IDLE);
   assign State         = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (READ_LAT 2 and 1)
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       busy_a, busy_b;
   logic [1:0] state_a, state_b;
   int         tests = 0;
   int         fails = 0;

   always #5 clock = ~clock;

   mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
   mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) ifb ();

   mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .READ_LAT(2)) dut (
      .clock (clock), .reset (reset), .bus (ifa.slave), .busy (busy_a), .State (state_a)
   );
   mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .READ_LAT(1)) dut_lat1 (
      .clock (clock), .reset (reset), .bus (ifb.slave), .busy (busy_b), .State (state_b)
   );

   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];

   // One-cycle synchronous memories
   always @(posedge clock) begin
      if (ifa.mem_wr) mem_a[ifa.mem_addr[9:2]] <= ifa.mem_wdata;
      ifa.mem_rdata <= mem_a[ifa.mem_addr[9:2]];
      ifb.mem_rdata <= mem_b[ifb.mem_addr[9:2]];
   end

   typedef struct packed {
      logic        src_d;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t e_a, e_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && (ifa.if_ack || ifa.d_ack)) begin
         if (sb_a.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack_a: actual if_ack=%0b d_ack=%0b required none", ifa.if_ack, ifa.d_ack);
         end else begin
            e_a = sb_a.pop_front();
            chk("ack_src_a", {31'd0, ifa.d_ack}, {31'd0, e_a.src_d});
            if (e_a.chk) chk("rdata_a", e_a.src_d ? ifa.d_rdata : ifa.if_rdata, e_a.data);
         end
      end
      if (!reset && (ifb.if_ack || ifb.d_ack)) begin
         if (sb_b.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack_b: actual if_ack=%0b d_ack=%0b required none", ifb.if_ack, ifb.d_ack);
         end else begin
            e_b = sb_b.pop_front();
            chk("ack_src_b", {31'd0, ifb.d_ack}, {31'd0, e_b.src_d});
            if (e_b.chk) chk("rdata_b", e_b.src_d ? ifb.d_rdata : ifb.if_rdata, e_b.data);
         end
      end
   end

   task automatic drop_all();
      ifa.if_req = 1'b0;
      ifa.d_req  = 1'b0;
   endtask

   // Issue one access on dut; with extra=1 the request is held one cycle past ack.
   task automatic access(input bit src_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_data,
                         input int exp_lat, input bit extra);
      int n, acks, first, second, need;
      logic ack;
      need = extra ? 2 : 1;
      sb_a.push_back(exp_t'{src_d, ~we, exp_data});
      if (extra) sb_a.push_back(exp_t'{src_d, ~we, exp_data});
      if (src_d) begin
         ifa.d_req = 1'b1; ifa.d_we = we; ifa.d_addr = addr; ifa.d_wdata = wd;
      end else begin
         ifa.if_req = 1'b1; ifa.if_addr = addr;
      end
      n = 0; acks = 0; first = -1; second = -1;
      while (n < 24 && acks < need) begin
         @(posedge clock); #1;
         n++;
         ack = src_d ? ifa.d_ack : ifa.if_ack;
         chk("mem_wr", {31'd0, ifa.mem_wr}, {31'd0, (we && n == 1)});
         if (ack) begin
            acks++;
            if (acks == 1) first = n; else second = n;
         end
         if (!extra && acks == 1) drop_all();
         if (extra && first > 0 && n == first + 2) drop_all();
      end
      drop_all();
      chk("ack_count", acks, need);
      chk("ack_latency", first, exp_lat);
      if (extra) chk("ack_latency_2nd", second, 2 * exp_lat + 1);
      @(posedge clock); #1;
   endtask

   task automatic both_req();
      int n, acks;
`ifdef ARB_ROUND_ROBIN_EN
      sb_a.push_back(exp_t'{1'b0, 1'b1, 32'h8C010004});
      sb_a.push_back(exp_t'{1'b1, 1'b1, 32'hDEADBEEF});
`else
      sb_a.push_back(exp_t'{1'b1, 1'b1, 32'hDEADBEEF});
      sb_a.push_back(exp_t'{1'b0, 1'b1, 32'h8C010004});
`endif
      ifa.if_req = 1'b1; ifa.if_addr = 32'h10;
      ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 32'h40;
      n = 0; acks = 0;
      while (n < 40 && acks < 2) begin
         @(posedge clock); #1;
         n++;
         if (ifa.if_ack) begin acks++; ifa.if_req = 1'b0; end
         if (ifa.d_ack)  begin acks++; ifa.d_req  = 1'b0; end
      end
      drop_all();
      chk("both_acks", acks, 2);
      chk("both_done_cycle", n, 9);
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 32'd0;
         mem_b[i] = 32'd0;
      end
      mem_a[4] = 32'h8C010004;
      mem_b[4] = 32'h8C010004;
      ifa.if_req = 0; ifa.if_addr = 0; ifa.d_req = 0; ifa.d_we = 0; ifa.d_addr = 0; ifa.d_wdata = 0;
      ifb.if_req = 0; ifb.if_addr = 0; ifb.d_req = 0; ifb.d_we = 0; ifb.d_addr = 0; ifb.d_wdata = 0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_state", {30'd0, state_a}, 32'(IDLE));
      chk("rst_busy", {31'd0, busy_a}, 0);
      chk("rst_if_ack", {31'd0, ifa.if_ack}, 0);
      chk("rst_d_ack", {31'd0, ifa.d_ack}, 0);
      chk("rst_mem_wr", {31'd0, ifa.mem_wr}, 0);
      chk("rst_mem_addr", ifa.mem_addr, 0);
      chk("rst_rdata", ifa.if_rdata, 0);
      chk("rst_state_b", {30'd0, state_b}, 32'(IDLE));
      reset = 1'b0;
      @(posedge clock); #1;

      access(1'b0, 1'b0, 32'h10, 32'h0, 32'h8C010004, 4, 1'b0);
      access(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 2, 1'b0);
      access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4, 1'b0);

      both_req();
      both_req();

      sb_a.push_back(exp_t'{1'b1, 1'b1, 32'hDEADBEEF});
      ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 32'h40;
      repeat (2) begin @(posedge clock); #1; end
      chk("pre_reset_wait", {30'd0, state_a}, 32'(WAIT));
      reset = 1'b1;
      ifa.d_req = 1'b0;
      #1;
      chk("mid_reset_state", {30'd0, state_a}, 32'(IDLE));
      chk("mid_reset_busy", {31'd0, busy_a}, 0);
      chk("mid_reset_mem_wr", {31'd0, ifa.mem_wr}, 0);
      chk("mid_reset_d_ack", {31'd0, ifa.d_ack}, 0);
      sb_a.delete();
      @(negedge clock);
      reset = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4, 1'b0);

      access(1'b0, 1'b0, 32'h10, 32'h0, 32'h8C010004, 4, 1'b1);

      sb_b.push_back(exp_t'{1'b0, 1'b1, 32'h8C010004});
      ifb.if_req = 1'b1; ifb.if_addr = 32'h10;
      got = -1;
      chk("lat1_busy_n0", {31'd0, busy_b}, 0);
      for (int n = 1; n <= 6; n++) begin
         @(posedge clock); #1;
         chk("lat1_busy", {31'd0, busy_b}, {31'd0, (n >= 1 && n <= 3)});
         if (ifb.if_ack) begin
            got = n;
            ifb.if_req = 1'b0;
         end
      end
      ifb.if_req = 1'b0;
      chk("lat1_ack_latency", got, 3);

      repeat (3) @(posedge clock);
      #1;
      chk("sb_a_drained", sb_a.size(), 0);
      chk("sb_b_drained", sb_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
